option_fifo: RTL and testbench

- Upstream feeder for the solver. Holds every candidate option word for all row and column lines in one circular buffer.
- Streams each line to the solver as one line-index word followed by that line's option words.
- Takes the solver's keep/drop verdict on each option. Kept options are re-enqueued at the tail; dropped options are discarded.
- Maintains the per-line and total remaining-option counts that the solver reads.

---
 rtl/option_fifo_pkg.sv | 21 ++
 rtl/option_ram.sv | 34 +++
 rtl/option_fifo.sv | 175 +++++++++++++++++
 tb/tb_option_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/option_fifo_pkg.sv
// Shared types and default sizing for the option FIFO.
package option_fifo_pkg;

  localparam int unsigned MAX_SIZE_D = 11;
  localparam int unsigned WORD_W_D   = 16;
  localparam int unsigned DEPTH_D    = 1024;
  localparam int unsigned CNT_W_D    = 7;

  localparam int unsigned LINES  = 2 * MAX_SIZE_D;
  localparam int unsigned PTR_W  = $clog2(DEPTH_D);
  localparam int unsigned LINE_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    PRESENT,
    DONE
  } state_t;

endpackage

// File: rtl/option_ram.sv
// Simple dual-port buffer: one write and one registered read per cycle.
module option_ram #(
  parameter int unsigned DataW = 17,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  // Write port; storage itself is not reset, contents are tracked by pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; cleared on reset so the presented word starts at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/option_fifo.sv
// Circular buffer of line-index and option words feeding the solver. Kept options are
// re-enqueued at the tail, dropped ones discarded; per-line counts track what remains.
// Optional macro OPTION_FIFO_STALL_DETECT_EN: stop with stalled=1 after a full pass
// in which nothing was dropped.
module option_fifo
  import option_fifo_pkg::*;
#(
  parameter int unsigned MAX_SIZE = MAX_SIZE_D,
  parameter int unsigned WORD_W   = WORD_W_D,
  parameter int unsigned DEPTH    = DEPTH_D,
  parameter int unsigned CNT_W    = CNT_W_D
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_valid,
  input  logic [WORD_W-1:0]                  load_data,
  input  logic                               load_is_index,
  output logic                               load_ready,
  input  logic                               started,
  output logic [WORD_W-1:0]                  option,
  output logic                               option_valid,
  output logic                               option_is_index,
  input  logic                               next,
  input  logic                               put_back_to_FIFO,
  output logic [2*MAX_SIZE-1:0][CNT_W-1:0]   old_options_amnt,
  output logic [CNT_W-1:0]                   all_options_remaining,
  output logic                               overflow,
  output logic                               stalled
);

  localparam int unsigned NumLines = 2 * MAX_SIZE;
  localparam int unsigned AddrW    = $clog2(DEPTH);
  localparam int unsigned LineW    = $clog2(NumLines);
  localparam int unsigned SumW     = CNT_W + LineW + 1;

  state_t                           state_q, state_d;
  logic [AddrW-1:0]                 head_q, tail_q;
  logic [AddrW:0]                   occ_q;
  logic [LineW-1:0]                 cur_line_q;
  logic [NumLines-1:0][CNT_W-1:0]   cnt_q;
  logic                             overflow_q;

  logic             load_phase, full, load_fire, consume, keep, push, rd_en;
  logic             cur_is_idx, idx_ok, line_ok, stall_hit;
  logic [WORD_W-1:0] cur_word;
  logic [LineW-1:0]  idx_line;
  logic [WORD_W:0]   wr_data, rd_data;
  logic [SumW-1:0]   sum;

  assign load_phase = (state_q == IDLE) || (state_q == LOAD);
  assign full       = (occ_q == (AddrW+1)'(DEPTH));
  // started closes the load window in the same cycle it arrives
  assign load_ready = !rst && load_phase && !full && !((state_q == LOAD) && started);
  assign load_fire  = load_valid && load_ready;

  assign cur_word   = rd_data[WORD_W-1:0];
  assign cur_is_idx = rd_data[WORD_W];
  assign idx_line   = cur_word[LineW-1:0];
  assign idx_ok     = cur_word < WORD_W'(NumLines);
  assign line_ok    = {1'b0, cur_line_q} < (LineW+1)'(NumLines);

  assign consume = (state_q == PRESENT) && next;
  // Index words survive only while their line still has options.
  assign keep    = cur_is_idx ? (idx_ok && (cnt_q[idx_line] != '0)) : put_back_to_FIFO;
  assign push    = load_fire || (consume && keep);
  assign wr_data = load_fire ? {load_is_index, load_data} : rd_data;
  assign rd_en   = (state_q == FETCH);

  option_ram #(
    .DataW (WORD_W + 1),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (push),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (head_q),
    .rd_data_o (rd_data)
  );

  assign option           = cur_word;
  assign option_is_index  = cur_is_idx;
  assign option_valid     = (state_q == PRESENT);
  assign old_options_amnt = cnt_q;
  assign overflow         = overflow_q;

`ifdef OPTION_FIFO_STALL_DETECT_EN
  logic [AddrW:0] pass_q;
  logic           stalled_q;

  assign stall_hit = (pass_q >= occ_q);
  assign stalled   = stalled_q;

  // Words consumed since the last drop; a full pass of them means no progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q    <= '0;
      stalled_q <= 1'b0;
    end else begin
      if (consume) begin
        pass_q <= keep ? pass_q + 1'b1 : '0;
      end
      if ((state_q == FETCH) && (occ_q != '0) && stall_hit) begin
        stalled_q <= 1'b1;
      end
    end
  end
`else
  assign stall_hit = 1'b0;
  assign stalled   = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_valid) state_d = LOAD;
      LOAD:    if (started) state_d = FETCH;
      FETCH:   state_d = ((occ_q == '0) || stall_hit) ? DONE : PRESENT;
      PRESENT: if (next) state_d = FETCH;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, occupancy, current line and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      cur_line_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (consume) head_q <= head_q + 1'b1;
      case ({push, consume})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (load_fire && load_is_index) begin
        cur_line_q <= load_data[LineW-1:0];
      end else if (consume && cur_is_idx) begin
        cur_line_q <= idx_line;
      end
      if (load_valid && load_phase && full) overflow_q <= 1'b1;
    end
  end

  // Per-line counters: saturating increment on load, floored decrement on drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_fire && !load_is_index && line_ok) begin
      if (cnt_q[cur_line_q] != '1) cnt_q[cur_line_q] <= cnt_q[cur_line_q] + 1'b1;
    end else if (consume && !cur_is_idx && !put_back_to_FIFO && line_ok) begin
      if (cnt_q[cur_line_q] != '0) cnt_q[cur_line_q] <= cnt_q[cur_line_q] - 1'b1;
    end
  end

  // Total remaining options, saturating at all-ones.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NumLines; i++) begin
      sum = sum + SumW'(cnt_q[i]);
    end
    all_options_remaining = (|sum[SumW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_option_fifo.sv
// Randomized scoreboard bench for option_fifo with a queue-based reference model.
module tb_option_fifo;

  localparam int NL  = 22;
  localparam int DEP = 1024;
  localparam int CW  = 7;
  localparam int CMAX = (1 << CW) - 1;
`ifdef OPTION_FIFO_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0, load_is_index = 1'b0, load_ready;
  logic [15:0] load_data = '0;
  logic started = 1'b0, next = 1'b0, put_back = 1'b0;
  logic [15:0] option;
  logic option_valid, option_is_index, overflow, stalled;
  logic [NL-1:0][CW-1:0] old_options_amnt;
  logic [CW-1:0] all_options_remaining;

  always #5 clk = ~clk;

  option_fifo #(
    .MAX_SIZE (11),
    .WORD_W   (16),
    .DEPTH    (DEP),
    .CNT_W    (CW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_valid            (load_valid),
    .load_data             (load_data),
    .load_is_index         (load_is_index),
    .load_ready            (load_ready),
    .started               (started),
    .option                (option),
    .option_valid          (option_valid),
    .option_is_index       (option_is_index),
    .next                  (next),
    .put_back_to_FIFO      (put_back),
    .old_options_amnt      (old_options_amnt),
    .all_options_remaining (all_options_remaining),
    .overflow              (overflow),
    .stalled               (stalled)
  );

  // Reference model: buffer contents, per-line counts, expected presentations.
  logic [16:0] mdl[$];
  logic [16:0] exp_q[$];
  int amnt[NL];
  int cur, pass_cnt;
  bit m_done, m_stalled;
  bit verdicts[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_total();
    int s = 0;
    for (int l = 0; l < NL; l++) s += amnt[l];
    return (s > CMAX) ? CMAX : s;
  endfunction

  task automatic check_counts(input string tag);
    for (int l = 0; l < NL; l++) chk($sformatf("%s amnt[%0d]", tag, l), old_options_amnt[l], amnt[l]);
    chk({tag, " total"}, all_options_remaining, model_total());
  endtask

  task automatic model_consume(input bit kp);
    logic [16:0] e;
    bit keepit;
    int w;
    e = mdl.pop_front();
    w = int'(e[15:0]);
    if (e[16]) begin
      cur = w;
      keepit = (w < NL) && (amnt[w] > 0);
    end else begin
      keepit = kp;
      if (!kp && amnt[cur] > 0) amnt[cur]--;
    end
    if (keepit) mdl.push_back(e);
    pass_cnt = keepit ? pass_cnt + 1 : 0;
    if (mdl.size() == 0) m_done = 1'b1;
    else if (STALL_EN && pass_cnt >= mdl.size()) begin
      m_stalled = 1'b1;
      m_done = 1'b1;
    end
    if (!m_done) exp_q.push_back(mdl[0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b0; started = 1'b0; next = 1'b0; put_back = 1'b0;
    mdl.delete(); exp_q.delete(); verdicts.delete();
    for (int l = 0; l < NL; l++) amnt[l] = 0;
    cur = 0; pass_cnt = 0; m_done = 1'b0; m_stalled = 1'b0;
    @(negedge clk);
    chk("rst option_valid", option_valid, 0);
    chk("rst option", option, 0);
    chk("rst option_is_index", option_is_index, 0);
    chk("rst load_ready", load_ready, 0);
    chk("rst overflow", overflow, 0);
    chk("rst stalled", stalled, 0);
    check_counts("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle load_ready", load_ready, 1);
  endtask

  task automatic load_word(input bit is_idx, input logic [15:0] w);
    @(negedge clk);
    load_valid = 1'b1; load_is_index = is_idx; load_data = w;
    chk("load_ready", load_ready, (mdl.size() < DEP) ? 1 : 0);
    if (mdl.size() < DEP) begin
      mdl.push_back({is_idx, w});
      if (is_idx) cur = int'(w);
      else if (amnt[cur] < CMAX) amnt[cur]++;
    end
  endtask

  // Leaves the caller at the negedge where the first word should be presented.
  task automatic start_stream();
    @(negedge clk);
    load_valid = 1'b0; started = 1'b1;
    #1 chk("ready_at_start", load_ready, 0);
    m_done = (mdl.size() == 0);
    if (!m_done) exp_q.push_back(mdl[0]);
    @(negedge clk);
    started = 1'b0;
    chk("first_gap", option_valid, 0);
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input int keep_pct);
    bit kp;
    for (int i = 0; i < n && !m_done; i++) begin
      chk("present_valid", option_valid, 1);
      if (!option_valid) break;
      if (mdl[0][16]) kp = 1'($urandom_range(1, 0));
      else if (verdicts.size() > 0) kp = verdicts.pop_front();
      else kp = ($urandom_range(99, 0) < keep_pct);
      next = 1'b1; put_back = kp;
      model_consume(kp);
      @(negedge clk);
      next = 1'b0; put_back = 1'b0;
      chk("gap_valid", option_valid, 0);
      check_counts("cnt");
      @(negedge clk);
      if (m_done) begin
        chk("done_valid", option_valid, 0);
        chk("done_stalled", stalled, m_stalled);
        chk("exp_drained", exp_q.size(), 0);
      end
    end
  endtask

  task automatic reset_mid_present();
    if (!m_done) chk("pre_rst_valid", option_valid, 1);
    do_reset();
  endtask

  // Monitor: compare every freshly presented word against the scoreboard.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) prev_v = 1'b0;
    else begin
      if (option_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream: got word %0h, expected none", option);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", option, e[15:0]);
          chk("stream_is_index", option_is_index, e[16]);
        end
      end
      prev_v = option_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 11x11 board: every line one option.
    for (int l = 0; l < NL; l++) begin
      load_word(1'b1, 16'(l));
      load_word(1'b0, 16'($urandom_range(16'hFFFF, 0)));
    end
    start_stream();
    check_counts("board");
    chk("first_word", option, 0);
    chk("first_is_index", option_is_index, 1);
    run_stream(400, 50);
    reset_mid_present();

    // Directed keep/drop on lines 3, 5, 7, then keep everything.
    load_word(1'b1, 16'd3); load_word(1'b0, 16'h0AAA); load_word(1'b0, 16'h0BBB);
    load_word(1'b1, 16'd5); load_word(1'b0, 16'h0CCC);
    load_word(1'b1, 16'd7); load_word(1'b0, 16'h0DDD);
    verdicts = '{1'b0, 1'b1, 1'b0, 1'b1};
    start_stream();
    run_stream(40, 100);
    chk("stalled_final", stalled, m_stalled);
    chk("line3_count", old_options_amnt[3], 1);
    reset_mid_present();

    // Random lines with 0..3 options each.
    for (int l = 0; l < NL; l++) begin
      if ($urandom_range(3, 0) != 0) begin
        load_word(1'b1, 16'(l));
        for (int k = $urandom_range(3, 0); k > 0; k--) load_word(1'b0, 16'($urandom));
      end
    end
    start_stream();
    run_stream(300, 70);
    reset_mid_present();

    // Fill to DEPTH, attempt overflow, then stream across the wrap.
    for (int k = 0; k < DEP; k++) begin
      if (k % 32 == 0) load_word(1'b1, 16'((k / 32) % NL));
      else load_word(1'b0, 16'($urandom));
    end
    load_word(1'b1, 16'd3);
    @(negedge clk);
    load_valid = 1'b0;
    chk("overflow_set", overflow, 1);
    chk("ready_full", load_ready, 0);
    check_counts("full");
    start_stream();
    run_stream(1100, 95);
    reset_mid_present();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
